// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//
// Port 0 is the execute-stage issue path and port 1 is the branch/compare unit. A single
// operation is in flight at a time. It is granted round-robin, its operands and control are
// registered onto the ALU, the result and flags are captured one cycle later, and they are
// returned on the owner's response channel with backpressure.
//
// Ports:
//   clk, rst                        rising-edge clock, async active-low reset
//   req{0,1}_valid/_ready           request handshake (ready is combinational, IDLE only)
//   req{0,1}_a/_b/_op               operands and ALU control code
//   alu_a, alu_b, alu_ctrl          registered operands/control driven to the ALU
//   alu_result, alu_flags           ALU outputs, flags = {OverFlow, Carry, Zero, Negative}
//   rsp{0,1}_valid/_ready           response handshake, only the owner's valid is raised
//   rsp_result, rsp_flags           captured result/flags shared by both response channels
//   busy                            high whenever the sequencer is not idle
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;

  logic any_valid;
  logic winner;
  logic accept;
  logic rsp_ready_sel;

  // Winner is port 1 when it alone is valid; under contention the port that did not win last.
  assign any_valid = req0_valid | req1_valid;
  assign winner    = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign accept    = (state_q == StIdle) & any_valid;

  assign req0_ready = accept & ~winner;
  assign req1_ready = accept & winner;

  assign rsp_ready_sel = gnt_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          gnt_d      = winner;
          last_d     = winner;
          alu_a_d    = winner ? req1_a : req0_a;
          alu_b_d    = winner ? req1_b : req0_b;
          alu_ctrl_d = winner ? req1_op : req0_op;
          state_d    = StExec;
        end
      end
      StExec: begin
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        state_d      = StResp;
      end
      StResp: begin
        if (rsp_ready_sel) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      gnt_q        <= 1'b0;
      last_q       <= 1'b1;  // port 0 wins the first contention after reset
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= 3'b000;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'b0000;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_q       <= last_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp0_valid = (state_q == StResp) & ~gnt_q;
  assign rsp1_valid = (state_q == StResp) & gnt_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU hooked to the ALU ports.
// Expected responses are pushed to a scoreboard when a request is driven and popped when the
// matching response appears.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        busy;

  int nchecks = 0;
  int nerr    = 0;
  int cyc     = 0;

  // {port, result, flags}
  logic [36:0] sb_q[$];

  alu_arbiter #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  // Behavioural ALU: {OverFlow, Carry, Zero, Negative, Result}
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        v;
    logic        c;
    s = '0;
    r = '0;
    v = 1'b0;
    c = 1'b0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b001: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[31:0];
        c = ~s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = {31'b0, a == b};
      3'b101:  r = {31'b0, a != b};
      3'b110:  r = {31'b0, $signed(a) < $signed(b)};
      default: r = {31'b0, $signed(a) > $signed(b)};
    endcase
    return {v, c, (r == 32'd0), r[31], r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_ctrl);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    if (p == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic set_rsp_ready(input int p, input logic v);
    if (p == 0) rsp0_ready = v;
    else        rsp1_ready = v;
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rv(input int p);
    return (p == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  // One operation on port p, response stalled for `stall` cycles after it appears.
  task automatic do_op(input string tag, input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input int stall, input logic [31:0] er,
                       input logic [3:0] ef);
    int          n;
    logic [36:0] e;
    n = 0;
    sb_q.push_back({p[0], er, ef});
    set_rsp_ready(p, stall == 0);
    set_req(p, 1'b1, a, b, op);
    #1;
    while (!rdy(p) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/accept"}, rdy(p), 1'b1);
    if (!rdy(p)) begin
      set_req(p, 1'b0, a, b, op);
      void'(sb_q.pop_back());
      return;
    end
    @(posedge clk);
    #1;
    set_req(p, 1'b0, 32'd0, 32'd0, 3'b000);
    // Cycle N+1: operands on the ALU, no response yet.
    @(negedge clk);
    chk({tag, "/alu_a"}, alu_a, a);
    chk({tag, "/alu_b"}, alu_b, b);
    chk({tag, "/alu_ctrl"}, alu_ctrl, op);
    chk({tag, "/exec_busy"}, busy, 1'b1);
    chk({tag, "/exec_rsp"}, {rsp0_valid, rsp1_valid}, 2'b00);
    chk({tag, "/exec_rdy"}, {req0_ready, req1_ready}, 2'b00);
    // Cycle N+2: response presented on the owner only.
    @(negedge clk);
    chk({tag, "/rsp_valid"}, rv(p), 1'b1);
    chk({tag, "/rsp_other"}, rv(1 - p), 1'b0);
    if (sb_q.size() == 0) begin
      chk({tag, "/sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "/port"}, rsp1_valid, e[36]);
      chk({tag, "/result"}, rsp_result, e[35:4]);
      chk({tag, "/flags"}, rsp_flags, e[3:0]);
    end
    for (int i = 1; i <= stall; i++) begin
      @(negedge clk);
      chk({tag, "/stall_valid"}, rv(p), 1'b1);
      chk({tag, "/stall_result"}, rsp_result, er);
      chk({tag, "/stall_flags"}, rsp_flags, ef);
      chk({tag, "/stall_rdy"}, {req0_ready, req1_ready}, 2'b00);
    end
    set_rsp_ready(p, 1'b1);
    @(posedge clk);
    #1;
    set_rsp_ready(p, 1'b0);
    @(negedge clk);
    chk({tag, "/idle_busy"}, busy, 1'b0);
    chk({tag, "/idle_rsp"}, {rsp0_valid, rsp1_valid}, 2'b00);
    chk({tag, "/hold_result"}, rsp_result, er);
  endtask

  int          g_port[4];
  int          g_cyc[4];
  int          accepts;
  int          responses;
  logic [36:0] e;
  logic [3:0]  exp_order;

  initial begin
    rst = 1'b0;
    set_req(0, 1'b0, 32'd0, 32'd0, 3'b000);
    set_req(1, 1'b0, 32'd0, 32'd0, 3'b000);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Power-on reset values
    @(negedge clk);
    chk("por/busy", busy, 1'b0);
    chk("por/alu", {alu_a, alu_b, alu_ctrl}, 67'd0);
    chk("por/rsp", {rsp_result, rsp_flags}, 36'd0);
    chk("por/rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single add: signed overflow into negative
    do_op("add", 0, 32'h7FFF_FFFF, 32'h0000_0001, 3'b000, 0, 32'h8000_0000, 4'b1001);
    // Carry and zero on port 1
    do_op("carry", 1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 0, 32'h0000_0000, 4'b0110);

    // Reset mid-run
    #1 rst = 1'b0;
    #1;
    chk("rst/busy", busy, 1'b0);
    chk("rst/alu", {alu_a, alu_b, alu_ctrl}, 67'd0);
    chk("rst/rsp", {rsp_result, rsp_flags}, 36'd0);
    chk("rst/rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    set_req(0, 1'b1, 32'd1, 32'd2, 3'b000);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst/ready_after", {req0_ready, req1_ready}, 2'b10);
    set_req(0, 1'b0, 32'd0, 32'd0, 3'b000);

    // Backpressure: port 0 owns the ALU while port 1 waits behind a 5-cycle stall
    set_req(1, 1'b1, 32'd5, 32'd5, 3'b100);
    do_op("bp", 0, 32'hF0F0_1234, 32'hFF00_FF00, 3'b010, 5, 32'hF000_1200, 4'b0001);
    chk("bp/req1_granted", req1_ready, 1'b1);
    do_op("bp_eq", 1, 32'd5, 32'd5, 3'b100, 0, 32'd1, 4'b0000);

    // Reset during EXEC of a port 1 sub
    set_req(1, 1'b1, 32'd9, 32'd4, 3'b001);
    #1;
    chk("abort/accept", req1_ready, 1'b1);
    @(posedge clk);
    #1 set_req(1, 1'b0, 32'd0, 32'd0, 3'b000);
    #1;
    chk("abort/in_exec", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort/busy", busy, 1'b0);
    chk("abort/alu_a", alu_a, 32'd0);
    rsp1_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort/no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
    end

    // Contention straight out of reset: 0,1,0,1 three cycles apart
    set_req(0, 1'b1, 32'd3, 32'd5, 3'b110);
    set_req(1, 1'b1, 32'h0000_00F0, 32'h0000_000F, 3'b011);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("cont/first_win", {req0_ready, req1_ready}, 2'b10);
    accepts   = 0;
    responses = 0;
    for (int it = 0; it < 40 && responses < 4; it++) begin
      @(negedge clk);
      chk("cont/rsp_excl", rsp0_valid & rsp1_valid, 1'b0);
      if (rsp0_valid || rsp1_valid) begin
        responses++;
        if (sb_q.size() == 0) begin
          chk("cont/sb_empty", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("cont/port", rsp1_valid, e[36]);
          chk("cont/result", rsp_result, e[35:4]);
          chk("cont/flags", rsp_flags, e[3:0]);
        end
      end
      if (accepts < 4 && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
        g_port[accepts] = req1_ready ? 1 : 0;
        g_cyc[accepts]  = cyc;
        if (req1_ready) sb_q.push_back({1'b1, 32'h0000_00FF, 4'b0000});
        else            sb_q.push_back({1'b0, 32'h0000_0001, 4'b0000});
        accepts++;
        if (accepts == 4) begin
          @(posedge clk);
          #1;
          set_req(0, 1'b0, 32'd0, 32'd0, 3'b000);
          set_req(1, 1'b0, 32'd0, 32'd0, 3'b000);
        end
      end
    end
    chk("cont/accepts", accepts, 4);
    chk("cont/responses", responses, 4);
    exp_order = 4'b1010;
    for (int i = 0; i < accepts; i++) begin
      chk("cont/order", g_port[i], exp_order[i]);
      if (i > 0) chk("cont/spacing", g_cyc[i] - g_cyc[i-1], 3);
    end
    chk("sb/drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares the single combinational 32-bit ALU between two requesters: the execute-stage issue path (port 0) and the branch/compare unit (port 1). It accepts one operation at a time through valid/ready handshakes and grants round-robin. It drives registered operands and control onto the ALU, captures the ALU result and flags, and returns them on the granting requester's response channel with backpressure. It sits between the pipeline control logic and the ALU instance.

## Interface
- WIDTH, 32, operand/result width; must match the ALU.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req0_valid, req1_valid  in  1  request present.
- req0_ready, req1_ready  out  1  request accepted this cycle when valid is also high.
- req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands, two's complement.
- req0_op, req1_op  in  3  ALU control code (000 add, 001 sub, 010 and, 011 or, 100 eq, 101 ne, 110 lt, 111 gt).
- alu_a, alu_b  out  WIDTH  registered operands to the ALU.
- alu_ctrl  out  3  registered ALUControl to the ALU.
- alu_result  in  WIDTH  ALU Result.
- alu_flags  in  4  {OverFlow, Carry, Zero, Negative} from the ALU.
- rsp0_valid, rsp1_valid  out  1  response held for that requester.
- rsp0_ready, rsp1_ready  in  1  requester consumes the response.
- rsp_result  out  WIDTH  captured result, shared by both response channels.
- rsp_flags  out  4  captured flags, same ordering as alu_flags.
- busy  out  1  high whenever state != IDLE.

## Operation
- FSM states are IDLE, EXEC and RESP. A 1-bit register `gnt` holds the owner of the current operation. A 1-bit register `last` holds the most recently granted port.
- IDLE: the arbiter selects a winner. If only one port has valid high, that port wins. If both are valid, the port != `last` wins. Only the winner's reqN_ready is high; the other ready is low. Both readies are low outside IDLE.
- Request accept (reqN_valid & reqN_ready):
  - load alu_a, alu_b and alu_ctrl from port N;
  - set gnt = N and last = N;
  - go to EXEC.
- EXEC: the ALU settles combinationally. At the end of the cycle, capture alu_result and alu_flags into rsp_result and rsp_flags, then go to RESP.
- RESP: rsp{gnt}_valid is high and the other rspN_valid is low. rsp_result and rsp_flags stay stable until rsp{gnt}_ready is sampled high; then go to IDLE.
- alu_a, alu_b and alu_ctrl hold their last values outside EXEC. They change only on an accept.
- rsp_result and rsp_flags hold after the response handshake until the next EXEC capture.
- The arbiter does not interpret op codes. All 8 codes are forwarded unchanged, and compare results (0/1) are returned as ALU outputs them.
- Requesters must hold valid, operands and op stable until ready. The arbiter never drops a valid request. Lowering valid before ready is illegal.
- The response for one port is never presented on the other port.

## Timing
- Reset (rst low, asynchronous):
  - state = IDLE, gnt = 0, last = 1 (port 0 wins the first contention);
  - alu_a = alu_b = 0, alu_ctrl = 000;
  - rsp_result = 0, rsp_flags = 0000;
  - all rsp valids = 0, busy = 0.
  - Readies are combinational and follow IDLE arbitration as soon as rst is released.
- Reset during EXEC or RESP aborts the operation. No response is ever produced for it, and the requester must reissue.
- Latency: request accepted at edge of cycle N; alu ports carry the operands during N+1; rspN_valid is high from N+2.
- With rsp_ready held high, the response completes in N+2, IDLE is in N+3 and the next accept is in N+3. Peak throughput is one operation per 3 cycles.
- A new request that arrives while the arbiter is busy waits in its requester. Arbitration is re-evaluated every IDLE cycle.
- A response stall of any length keeps the FSM in RESP. Both readies stay low and no new grant occurs.
- Continuous contention strictly alternates: 0, 1, 0, 1, …

## Test plan
- Reset values: assert rst mid-run, then release. Required: all outputs hold the reset values above; req0_ready = 1 when only req0_valid = 1.
- Single add (real ALU instance): req0 with a = 0x7FFFFFFF, b = 0x00000001, op = 000. Required: alu_a = 0x7FFFFFFF during N+1; rsp0_valid at N+2 with rsp_result = 0x80000000 and rsp_flags = 1001; rsp1_valid stays 0.
- Carry/zero: req1 with a = 0xFFFFFFFF, b = 0x00000001, op = 000. Required: rsp1_valid with rsp_result = 0x00000000 and rsp_flags = 0110.
- Contention: both ports valid continuously for 4 operations, ops 110 (a = 3, b = 5) on port 0 and 011 (a = 0xF0, b = 0x0F) on port 1. Required: grant order 0, 1, 0, 1; port 0 results = 1; port 1 results = 0xFF; accepts 3 cycles apart.
- Backpressure: rsp0_ready low for 5 cycles after rsp0_valid. Required: rsp_result and rsp_flags stable, both readies low, and req1 not granted until the cycle after rsp0 is consumed.
- Reset mid-operation: assert rst during EXEC of a port 1 sub. Required: no rsp1_valid ever asserted for that op; after release, port 0 wins the first contention.
